// File: rtl/turn_signal_conditioner_if.sv
// Stalk-switch inputs and clean request outputs of the turn-signal conditioner.
// The conditioner takes the slave view; the driver and observer take the master view.
interface turn_signal_conditioner_if;
  logic left_raw;
  logic right_raw;
  logic left;
  logic right;
  logic hazard;
  logic blink_tick;

  modport master (
    output left_raw,
    output right_raw,
    input  left,
    input  right,
    input  hazard,
    input  blink_tick
  );

  modport slave (
    input  left_raw,
    input  right_raw,
    output left,
    output right,
    output hazard,
    output blink_tick
  );
endinterface

// File: rtl/turn_signal_conditioner.sv
// Synchronises and debounces raw turn-stalk switches, arbitrates left/right/hazard
// and generates the blink-rate tick that steps the downstream tail-light pattern.
module turn_signal_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_DIV       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  turn_signal_conditioner_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  // Channel 0 is the left stalk, channel 1 the right stalk.
  logic [1:0] raw;
  logic [1:0] deb;

  assign raw = {bus.right_raw, bus.left_raw};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   deb_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: every clocked register uses <= so all flops sample pre-edge values;
    // a blocking = here would let the synchroniser collapse into a single stage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
        db_cnt <= '0;
        deb_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
        if (synced == deb_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          deb_q  <= synced;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    assign deb[g] = deb_q;
  end

  logic dl;
  logic dr;

  assign dl = deb[0];
  assign dr = deb[1];

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its hold value first so every path through the case
  // assigns it; leaving a branch unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dl && dr) begin
          state_next = HAZARD;
        end else if (dl) begin
          state_next = LEFT;
        end else if (dr) begin
          state_next = RIGHT;
        end
      end
      LEFT: begin
        if (dr) begin
          state_next = HAZARD;
        end else if (!dl) begin
          state_next = IDLE;
        end
      end
      RIGHT: begin
        if (dl) begin
          state_next = HAZARD;
        end else if (!dr) begin
          state_next = IDLE;
        end
      end
      HAZARD: begin
        if (!dl && !dr) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The blink phase restarts on every state change so the downstream pattern
  // realigns with the newly selected request.
  logic [BL_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
    end else if ((state_next != state) || (state == IDLE)) begin
      blink_cnt <= '0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
    end
  end

  assign bus.left       = (state == LEFT)  || (state == HAZARD);
  assign bus.right      = (state == RIGHT) || (state == HAZARD);
  assign bus.hazard     = (state == HAZARD);
  assign bus.blink_tick = (blink_cnt == BL_LAST) && (state != IDLE);

  a_no_dual_request: assert property (@(posedge clk) disable iff (!reset)
    !(bus.left && bus.right) || bus.hazard);

  a_no_left_right_hop: assert property (@(posedge clk) disable iff (!reset)
    (state == LEFT) |=> (state != RIGHT));

  a_no_right_left_hop: assert property (@(posedge clk) disable iff (!reset)
    (state == RIGHT) |=> (state != LEFT));

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Self-checking bench: directed scenarios pin the timing with literal expectations,
// then random stalk activity is compared every cycle against a behavioural model.
module tb_turn_signal_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int B = 8;

  localparam int O_LEFT   = 0;
  localparam int O_RIGHT  = 1;
  localparam int O_HAZARD = 2;
  localparam int O_TICK   = 3;

  logic clk = 1'b0;
  logic reset;

  turn_signal_conditioner_if bus ();

  turn_signal_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .BLINK_DIV      (B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic out_sel(input int which);
    case (which)
      O_LEFT:   return bus.left;
      O_RIGHT:  return bus.right;
      O_HAZARD: return bus.hazard;
      default:  return bus.blink_tick;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int max_edges, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max_edges && !found; i++) begin
      @(posedge clk);
      #1;
      if (out_sel(which) === val) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 left, 2 right, 3 hazard. age = edges since the state was entered.
  int mstate = 0;
  int age    = 0;
  bit mdl    = 1'b0;
  bit mdr    = 1'b0;
  bit hl[$];
  bit hr[$];

  function automatic int model_next(input int cur, input bit l, input bit r);
    int single;
    if (!l && !r) return 0;
    if ((l && r) || cur == 3) return 3;
    single = l ? 1 : 2;
    return (cur == 0 || cur == single) ? single : 3;
  endfunction

  // A debounced level flips once the synchronised level seen by the last D edges
  // has disagreed with it every time; hist[k] is the raw level sampled k edges ago.
  function automatic bit window_flips(input bit hist[$], input bit cur);
    for (int k = S; k < S + D; k++) begin
      bit v;
      v = (k < hist.size()) ? hist[k] : 1'b0;
      if (v == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    mstate = 0;
    age    = 0;
    mdl    = 1'b0;
    mdr    = 1'b0;
    hl.delete();
    hr.delete();
    for (int k = 0; k < S + D; k++) begin
      hl.push_back(1'b0);
      hr.push_back(1'b0);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
    end else begin
      int ns;
      ns = model_next(mstate, mdl, mdr);
      age = (ns != mstate) ? 0 : age + 1;
      mstate = ns;
      hl.push_front(bus.left_raw);
      hr.push_front(bus.right_raw);
      if (hl.size() > S + D) void'(hl.pop_back());
      if (hr.size() > S + D) void'(hr.pop_back());
      if (window_flips(hl, mdl)) mdl = ~mdl;
      if (window_flips(hr, mdr)) mdr = ~mdr;
    end
  end

  always @(negedge clk) begin
    check("cmp_left",   {31'd0, bus.left},   {31'd0, (mstate == 1 || mstate == 3)});
    check("cmp_right",  {31'd0, bus.right},  {31'd0, (mstate == 2 || mstate == 3)});
    check("cmp_hazard", {31'd0, bus.hazard}, {31'd0, (mstate == 3)});
    check("cmp_tick",   {31'd0, bus.blink_tick},
          {31'd0, (mstate != 0) && ((age % B) == B - 1)});
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    bit bad;
    bit found;

    reset = 1'b1;
    bus.left_raw  = 1'b1;
    bus.right_raw = 1'b0;
    #1 reset = 1'b0;

    // 1: reset holds everything low even with left_raw high.
    #11;
    check("t1_reset_left",   {31'd0, bus.left},       32'd0);
    check("t1_reset_right",  {31'd0, bus.right},      32'd0);
    check("t1_reset_hazard", {31'd0, bus.hazard},     32'd0);
    check("t1_reset_tick",   {31'd0, bus.blink_tick}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_left_edge%0d", k), {31'd0, bus.left}, {31'd0, k >= 7});
      check($sformatf("t1_tick_edge%0d", k), {31'd0, bus.blink_tick}, {31'd0, k == 14});
    end
    bus.left_raw = 1'b0;
    wait_for(O_LEFT, 1'b0, 20, "t1_left_fall");

    // 2: a 3-cycle pulse is rejected, a 4-cycle pulse gets through.
    @(posedge clk);
    #2 bus.left_raw = 1'b1;
    repeat (3) @(posedge clk);
    #2 bus.left_raw = 1'b0;
    seen = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1 seen |= bus.left;
    end
    check("t2_pulse3_rejected", {31'd0, seen}, 32'd0);
    @(posedge clk);
    #2 bus.left_raw = 1'b1;
    repeat (4) @(posedge clk);
    #2 bus.left_raw = 1'b0;
    seen = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1 seen |= bus.left;
    end
    check("t2_pulse4_accepted", {31'd0, seen}, 32'd1);
    wait_for(O_LEFT, 1'b0, 20, "t2_left_fall");

    // 3: held left, tick every 8 edges, release after 7 edges with no idle tick.
    @(posedge clk);
    #2 bus.left_raw = 1'b1;
    wait_for(O_LEFT, 1'b1, 12, "t3_left_rise");
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1 check($sformatf("t3_tick_k%0d", k), {31'd0, bus.blink_tick}, {31'd0, (k % 8) == 7});
    end
    check("t3_right_low",  {31'd0, bus.right},  32'd0);
    check("t3_hazard_low", {31'd0, bus.hazard}, 32'd0);
    repeat (9) @(posedge clk);
    #2 bus.left_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k <= 7) check($sformatf("t3_release_left_k%0d", k), {31'd0, bus.left}, {31'd0, k < 7});
      else        check($sformatf("t3_idle_tick_k%0d", k), {31'd0, bus.blink_tick}, 32'd0);
    end

    // 4: left then right -> hazard with restarted phase; hazard latched on single release.
    @(posedge clk);
    #2 bus.left_raw = 1'b1;
    repeat (20) @(posedge clk);
    #2 bus.right_raw = 1'b1;
    wait_for(O_HAZARD, 1'b1, 12, "t4_hazard_rise");
    check("t4_left",  {31'd0, bus.left},  32'd1);
    check("t4_right", {31'd0, bus.right}, 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1 check($sformatf("t4_tick_k%0d", k), {31'd0, bus.blink_tick}, {31'd0, k == 7});
    end
    #1 bus.left_raw = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("t4_hazard_held", {31'd0, bus.hazard}, 32'd1);
    check("t4_left_held",   {31'd0, bus.left},   32'd1);
    bus.right_raw = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t4_idle_left",   {31'd0, bus.left},   32'd0);
    check("t4_idle_right",  {31'd0, bus.right},  32'd0);
    check("t4_idle_hazard", {31'd0, bus.hazard}, 32'd0);

    // 5: both rise together -> straight to hazard, never a single request.
    @(posedge clk);
    #2;
    bus.left_raw  = 1'b1;
    bus.right_raw = 1'b1;
    bad   = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(posedge clk);
      #1;
      if (bus.left !== bus.right) bad = 1'b1;
      if (bus.hazard) found = 1'b1;
    end
    check("t5_hazard_direct", {31'd0, found}, 32'd1);
    check("t5_no_single_req", {31'd0, bad},   32'd0);

    // 6: reset during hazard at cnt=5 clears everything before the next edge.
    repeat (5) @(posedge clk);
    #2;
    reset         = 1'b0;
    bus.left_raw  = 1'b0;
    bus.right_raw = 1'b0;
    #1;
    check("t6_async_left",   {31'd0, bus.left},       32'd0);
    check("t6_async_right",  {31'd0, bus.right},      32'd0);
    check("t6_async_hazard", {31'd0, bus.hazard},     32'd0);
    check("t6_async_tick",   {31'd0, bus.blink_tick}, 32'd0);
    @(posedge clk);
    #1 check("t6_no_tick_after", {31'd0, bus.blink_tick}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Random stalk activity with occasional mid-cycle resets; the model does the checking.
    for (int seg = 0; seg < 250; seg++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #2 reset = 1'b1;
      end
      bus.left_raw  = $urandom_range(0, 1) == 1;
      bus.right_raw = $urandom_range(0, 1) == 1;
      repeat ($urandom_range(1, 14)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
